// File: rtl/l2_cacheline_adapter.sv
// Bridges the L2 pmem port to a narrow burst memory bus: one cacheline request becomes a
// BEATS-long burst, with a single-cycle completion pulse and a stable assembled read line.
module l2_cacheline_adapter #(
    parameter int unsigned S_LINE   = 256,
    parameter int unsigned S_BURST  = 64,
    parameter int unsigned S_OFFSET = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        line_addr_i,
    input  logic [S_LINE-1:0]  line_i,
    input  logic               read_i,
    input  logic               write_i,
    output logic [S_LINE-1:0]  line_o,
    output logic               resp_o,
    output logic [31:0]        burst_addr_o,
    output logic [S_BURST-1:0] burst_o,
    input  logic [S_BURST-1:0] burst_i,
    output logic               burst_read_o,
    output logic               burst_write_o,
    input  logic               burst_resp_i
);

    localparam int unsigned BEATS = S_LINE / S_BURST;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned SEL_W = $clog2(S_BURST);
    localparam int unsigned IDX_W = CNT_W + SEL_W;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);

    typedef enum logic [2:0] {StIdle, StRd, StWr, StDone, StRearm} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [31:S_OFFSET]  addr_q, addr_d;
    logic [S_LINE-1:0]   buf_q, buf_d;
    logic [S_LINE-1:0]   line_q, line_d;
    logic                wr_q, wr_d;
    logic [IDX_W-1:0]    beat_base;
    logic                beat;
    logic                last_beat;
    logic                unused_addr_bits;

    assign unused_addr_bits = ^line_addr_i[S_OFFSET-1:0];

    assign beat      = burst_resp_i && ((state_q == StRd) || (state_q == StWr));
    assign last_beat = beat && (cnt_q == CNT_LAST);
    assign beat_base = {cnt_q, {SEL_W{1'b0}}};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (write_i) begin
                    state_d = StWr;
                end else if (read_i) begin
                    state_d = StRd;
                end
            end
            StRd, StWr: begin
                if (last_beat) begin
                    state_d = StDone;
                end
            end
            StDone: state_d = StRearm;
            // Only the strobe of the request just served gates re-entry to idle.
            StRearm: begin
                if (wr_q ? !write_i : !read_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            addr_q <= '0;
            buf_q  <= '0;
            line_q <= '0;
            wr_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            addr_q <= addr_d;
            buf_q  <= buf_d;
            line_q <= line_d;
            wr_q   <= wr_d;
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        addr_d = addr_q;
        buf_d  = buf_q;
        line_d = line_q;
        wr_d   = wr_q;
        if (state_q == StIdle) begin
            cnt_d = '0;
            if (write_i) begin
                addr_d = line_addr_i[31:S_OFFSET];
                buf_d  = line_i;
                wr_d   = 1'b1;
            end else if (read_i) begin
                addr_d = line_addr_i[31:S_OFFSET];
                wr_d   = 1'b0;
            end
        end else if (beat) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (state_q == StRd) begin
                buf_d[beat_base +: S_BURST] = burst_i;
                // Publish the whole line at once so L2 never sees a partial fill.
                if (last_beat) begin
                    line_d = buf_d;
                end
            end
        end
    end

    always_comb begin
        burst_read_o  = (state_q == StRd);
        burst_write_o = (state_q == StWr);
        resp_o        = (state_q == StDone);
        line_o        = line_q;
        burst_addr_o  = '0;
        burst_o       = '0;
        if ((state_q == StRd) || (state_q == StWr)) begin
            burst_addr_o = {addr_q, {S_OFFSET{1'b0}}};
        end
        if (state_q == StWr) begin
            burst_o = buf_q[beat_base +: S_BURST];
        end
    end

endmodule

// File: tb/tb_l2_cacheline_adapter.sv
// Directed bench for l2_cacheline_adapter: stimulus tasks queue expected completions and
// write beats; a negedge monitor pops and compares whenever the DUT presents them.
module tb_l2_cacheline_adapter;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [31:0]  line_addr_i = '0;
    logic [255:0] line_i = '0;
    logic         read_i = 1'b0;
    logic         write_i = 1'b0;
    logic [255:0] line_o;
    logic         resp_o;
    logic [31:0]  burst_addr_o;
    logic [63:0]  burst_o;
    logic [63:0]  burst_i = '0;
    logic         burst_read_o;
    logic         burst_write_o;
    logic         burst_resp_i = 1'b0;

    int checks = 0;
    int errors = 0;
    int resp_count = 0;
    logic prev_resp = 1'b0;
    logic [255:0] exp_line = '0;
    logic [256:0] rq[$];
    logic [63:0]  wq[$];

    l2_cacheline_adapter dut (
        .clk          (clk),
        .rst          (rst),
        .line_addr_i  (line_addr_i),
        .line_i       (line_i),
        .read_i       (read_i),
        .write_i      (write_i),
        .line_o       (line_o),
        .resp_o       (resp_o),
        .burst_addr_o (burst_addr_o),
        .burst_o      (burst_o),
        .burst_i      (burst_i),
        .burst_read_o (burst_read_o),
        .burst_write_o(burst_write_o),
        .burst_resp_i (burst_resp_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: completions and write beats are checked as the DUT presents them.
    always @(negedge clk) begin
        if (!rst) begin
            prev_resp = 1'b0;
        end else begin
            if (burst_read_o || burst_write_o) begin
                check("strobe_exclusive", {255'b0, burst_read_o & burst_write_o}, '0);
            end
            if (resp_o) begin
                resp_count++;
                check("resp_single_cycle", {255'b0, prev_resp}, '0);
                if (rq.size() == 0) begin
                    check("resp_unexpected", {255'b0, resp_o}, '0);
                end else begin
                    logic [256:0] e;
                    e = rq.pop_front();
                    check("resp_line", line_o, e[255:0]);
                end
            end
            if (burst_write_o && burst_resp_i) begin
                if (wq.size() == 0) begin
                    check("wr_beat_unexpected", {255'b0, burst_write_o}, '0);
                end else begin
                    logic [63:0] b;
                    b = wq.pop_front();
                    check("wr_beat_data", {192'b0, burst_o}, {192'b0, b});
                end
            end
            prev_resp = resp_o;
        end
    end

    task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_addr,
                           input logic [255:0] line, input logic [15:0] pat, input int plen,
                           input int hold);
        int idx = 0;
        int k = 0;
        int guard = 0;
        read_i = 1'b1;
        line_addr_i = addr;
        exp_line = line;
        rq.push_back({1'b0, line});
        step();
        while (!burst_read_o && guard < 20) begin
            step();
            guard++;
        end
        check("rd_start", {255'b0, burst_read_o}, 256'd1);
        line_addr_i = ~addr;
        check("rd_addr", {224'b0, burst_addr_o}, {224'b0, exp_addr});
        while (idx < 4) begin
            burst_resp_i = (k < plen) ? pat[k] : 1'b1;
            burst_i = burst_resp_i ? line[idx*64 +: 64] : 64'hBAD0_BAD0_BAD0_BAD0;
            check("rd_strobe_held", {255'b0, burst_read_o}, 256'd1);
            step();
            if (burst_resp_i) idx++;
            k++;
        end
        burst_resp_i = 1'b0;
        burst_i = '0;
        check("rd_resp_latency", {255'b0, resp_o}, 256'd1);
        check("rd_done_strobe", {255'b0, burst_read_o}, '0);
        check("rd_done_addr", {224'b0, burst_addr_o}, '0);
        for (int h = 0; h < hold; h++) begin
            step();
            check("rd_no_rearm", {255'b0, burst_read_o}, '0);
        end
        read_i = 1'b0;
        step();
        step();
        check("rd_idle", {255'b0, burst_read_o}, '0);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] exp_addr,
                            input logic [255:0] line, input logic [15:0] pat, input int plen);
        int idx = 0;
        int k = 0;
        int guard = 0;
        write_i = 1'b1;
        line_i = line;
        line_addr_i = addr;
        for (int i = 0; i < 4; i++) wq.push_back(line[i*64 +: 64]);
        rq.push_back({1'b1, exp_line});
        step();
        while (!burst_write_o && guard < 20) begin
            step();
            guard++;
        end
        check("wr_start", {255'b0, burst_write_o}, 256'd1);
        line_i = ~line;
        line_addr_i = ~addr;
        check("wr_addr", {224'b0, burst_addr_o}, {224'b0, exp_addr});
        while (idx < 4) begin
            burst_resp_i = (k < plen) ? pat[k] : 1'b1;
            check("wr_strobe_held", {255'b0, burst_write_o}, 256'd1);
            step();
            if (burst_resp_i) idx++;
            k++;
        end
        burst_resp_i = 1'b0;
        check("wr_resp_latency", {255'b0, resp_o}, 256'd1);
        check("wr_done_strobe", {255'b0, burst_write_o}, '0);
        check("wr_line_kept", line_o, exp_line);
        write_i = 1'b0;
    endtask

    initial begin
        int rc0;
        rst = 1'b0;
        repeat (2) step();
        check("rst_line", line_o, '0);
        check("rst_resp", {255'b0, resp_o}, '0);
        check("rst_rd", {255'b0, burst_read_o}, '0);
        check("rst_wr", {255'b0, burst_write_o}, '0);
        check("rst_addr", {224'b0, burst_addr_o}, '0);
        check("rst_data", {192'b0, burst_o}, '0);
        rst = 1'b1;
        step();

        // Back-to-back read, request held 3 cycles past completion.
        do_read(32'h0000_1234, 32'h0000_1220,
                {64'h4, 64'h3, 64'h2, 64'h1}, 16'h0, 0, 3);

        // Writeback; line_o must keep the previous fill.
        do_write(32'h0000_2047, 32'h0000_2040,
                 {64'hD, 64'hC, 64'hB, 64'hA}, 16'h0, 0);
        step();
        step();

        // Read with beat pattern 1,0,0,1,1,0,1.
        do_read(32'h0000_301F, 32'h0000_3000,
                {64'h4444_0000_0000_0004, 64'h3333_0000_0000_0003,
                 64'h2222_0000_0000_0002, 64'h1111_0000_0000_0001}, 16'h0059, 7, 0);

        // Write and read together: writeback first, then the pending fill.
        rc0 = resp_count;
        read_i = 1'b1;
        do_write(32'h0000_5008, 32'h0000_5000,
                 {64'hF4, 64'hF3, 64'hF2, 64'hF1}, 16'h001B, 5);
        do_read(32'h0000_6010, 32'h0000_6000,
                {64'hE4, 64'hE3, 64'hE2, 64'hE1}, 16'h0, 0, 0);
        check("both_resp_count", 256'(resp_count - rc0), 256'd2);

        // Reset after two read beats aborts everything.
        read_i = 1'b1;
        line_addr_i = 32'h0000_7000;
        step();
        burst_resp_i = 1'b1;
        burst_i = 64'h11;
        step();
        burst_i = 64'h22;
        step();
        burst_resp_i = 1'b0;
        rst = 1'b0;
        #1;
        check("abort_line", line_o, '0);
        check("abort_resp", {255'b0, resp_o}, '0);
        check("abort_rd", {255'b0, burst_read_o}, '0);
        check("abort_wr", {255'b0, burst_write_o}, '0);
        check("abort_addr", {224'b0, burst_addr_o}, '0);
        check("abort_data", {192'b0, burst_o}, '0);
        exp_line = '0;
        read_i = 1'b0;
        step();
        rst = 1'b1;
        step();
        step();
        check("post_rst_idle", {255'b0, burst_read_o}, '0);
        do_read(32'h0000_8000, 32'h0000_8000,
                {64'h8D, 64'h8C, 64'h8B, 64'h8A}, 16'h0, 0, 1);

        repeat (3) step();
        check("resp_queue_drained", 256'(rq.size()), '0);
        check("beat_queue_drained", 256'(wq.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1);
    end

endmodule
